// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared types and constants for the fetch line buffer.              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+

// Fallback encodings matching Sysbus.defs when it is not included first.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package fetch_pkg;

    typedef enum logic [2:0] {
        REQ   = 3'd0,
        RESP  = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_e;

    localparam int BEATS_PER_LINE = 8;
    localparam int WORDS_PER_LINE = 16;

    localparam logic [12:0] FETCH_READ_TAG =
        (13'(`SYSBUS_READ) << 8) | (13'(`SYSBUS_MEMORY) << 12);

endpackage

`default_nettype wire

// File: rtl/fetch_line_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_line_store                                                   |
// | 16x32 instruction line array: one 64-bit beat write, one word read.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fetch_line_store
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_beat,
    input  logic [63:0] i_wr_data,
    input  logic [3:0]  i_rd_idx,
    output logic [31:0] o_rd_word
);

    logic [31:0] r_words [WORDS_PER_LINE];

    // Contents are only read after a full line has been written, so no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_words[{i_wr_beat, 1'b0}] <= i_wr_data[31:0];
            r_words[{i_wr_beat, 1'b1}] <= i_wr_data[63:32];
        end
    end

    assign o_rd_word = r_words[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_line_buffer                                                  |
// | Fetches 64-byte lines over Sysbus and streams instructions to decode.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst_word,
    output logic [63:0]               inst_pc,
    output logic                      halted
);

    localparam logic [63:0] c_LINE_MASK = ~64'(LINE_BYTES - 1);
    localparam logic [63:0] c_LINE_STEP = 64'(LINE_BYTES);

    fetch_state_e r_state, w_state_nxt;
    logic [63:0]  r_fetch_pc, r_line_addr, r_req_addr;
    logic [63:0]  w_fetch_pc_nxt, w_line_nxt;
    logic [3:0]   r_beat_cnt, r_word_idx;
    logic         r_redir_pend;
    logic         w_beat_acc, w_inst_fire, w_word_zero, w_last_word;
    logic [31:0]  w_rd_word;
    logic         w_unused;

    // Only one request is ever outstanding, so the response tag carries nothing.
    assign w_unused = ^bus_resptag;

    fetch_line_store u_store (
        .clk       (clk),
        .i_wr_en   (w_beat_acc && (r_state == RESP)),
        .i_wr_beat (r_beat_cnt[2:0]),
        .i_wr_data (bus_resp),
        .i_rd_idx  (r_word_idx),
        .o_rd_word (w_rd_word)
    );

    assign w_word_zero = (w_rd_word == 32'd0);
    assign w_last_word = (r_word_idx == 4'(WORDS_PER_LINE - 1));
    assign w_beat_acc  = bus_respack;
    assign w_inst_fire = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ: begin
                if (bus_reqack) begin
                    w_state_nxt = (r_redir_pend || redirect_valid) ? FLUSH : RESP;
                end
            end
            RESP: begin
                if (redirect_valid) begin
                    w_state_nxt = FLUSH;
                end else if (w_beat_acc && r_beat_cnt == 4'(BEATS_PER_LINE - 1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    w_state_nxt = REQ;
                end else if (w_word_zero) begin
                    w_state_nxt = HALT;
                end else if (w_inst_fire && w_last_word) begin
                    w_state_nxt = REQ;
                end
            end
            FLUSH: begin
                if (r_beat_cnt == 4'(BEATS_PER_LINE) ||
                    (w_beat_acc && r_beat_cnt == 4'(BEATS_PER_LINE - 1))) begin
                    w_state_nxt = REQ;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_comb begin
        bus_reqcyc  = !reset && (r_state == REQ);
        bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(r_req_addr) : '0;
        bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(FETCH_READ_TAG) : '0;
        bus_respack = !reset && bus_respcyc &&
                      ((r_state == RESP) ||
                       (r_state == FLUSH && r_beat_cnt < 4'(BEATS_PER_LINE)));
        inst_valid  = !reset && (r_state == DRAIN) && !w_word_zero;
        inst_word   = inst_valid ? w_rd_word : 32'd0;
        inst_pc     = inst_valid ? (r_line_addr + {58'd0, r_word_idx, 2'b00}) : 64'd0;
        halted      = !reset && (r_state == HALT);
    end

    assign w_fetch_pc_nxt = redirect_valid ? redirect_pc :
                            w_inst_fire    ? (r_fetch_pc + 64'd4) : r_fetch_pc;
    assign w_line_nxt     = redirect_valid ? (redirect_pc & c_LINE_MASK) :
                            (w_inst_fire && w_last_word) ? (r_line_addr + c_LINE_STEP) :
                            r_line_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= entry;
            r_line_addr  <= entry & c_LINE_MASK;
            r_req_addr   <= entry & c_LINE_MASK;
            r_beat_cnt   <= 4'd0;
            r_word_idx   <= 4'd0;
            r_redir_pend <= 1'b0;
        end else begin
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_line_addr <= w_line_nxt;
            // Request address is frozen while in REQ so a redirect cannot move it before ack.
            if (w_state_nxt == REQ && r_state != REQ) begin
                r_req_addr <= w_line_nxt;
            end
            if (r_state == REQ) begin
                r_beat_cnt <= 4'd0;
            end else if (w_beat_acc) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
            if (r_state == RESP && w_state_nxt == DRAIN) begin
                r_word_idx <= r_fetch_pc[5:2];
            end else if (w_inst_fire) begin
                r_word_idx <= r_word_idx + 4'd1;
            end
            if (r_state == REQ && !bus_reqack) begin
                r_redir_pend <= r_redir_pend || redirect_valid;
            end else begin
                r_redir_pend <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_line_buffer                                               |
// | Scoreboard bench: directed cases, Sysbus responder, output monitor.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] entry = 64'h1000;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag;
    logic [12:0] bus_resptag = 13'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        inst_valid, inst_ready, halted;
    logic [31:0] inst_word;
    logic [63:0] inst_pc;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } inst_t;

    inst_t       exp_inst[$];
    logic [63:0] exp_req[$];
    int          checks = 0;
    int          errors = 0;
    bit          resp_gaps = 1'b0;
    bit          ready_toggle = 1'b0;
    int          ack_delay = 0;
    bit          zero_en = 1'b0;
    logic [63:0] zero_addr = 64'd0;

    always #5 clk = ~clk;

    fetch_line_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus_reqcyc     (bus_reqcyc),
        .bus_reqack     (bus_reqack),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_respcyc    (bus_respcyc),
        .bus_respack    (bus_respack),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    // Memory image: word at 0x1000 is 1, each following word one larger.
    function automatic logic [31:0] mem(input logic [63:0] a);
        if (zero_en && a == zero_addr) return 32'd0;
        return 32'((a - 64'h1000) >> 2) + 32'd1;
    endfunction

    initial begin : ready_drv
        inst_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            inst_ready = ready_toggle ? ~inst_ready : 1'b1;
        end
    end

    initial begin : responder
        int          wait_cnt;
        int          beat;
        bit          busy;
        logic [63:0] addr, s_addr;
        bit          s_req_hs, s_beat_hs, s_reqcyc, s_rst;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'd0;
        wait_cnt = 0; beat = 0; busy = 1'b0; addr = 64'd0;
        forever begin
            @(negedge clk);
            s_req_hs  = bus_reqcyc && bus_reqack;
            s_beat_hs = bus_respcyc && bus_respack;
            s_reqcyc  = bus_reqcyc;
            s_addr    = bus_req;
            s_rst     = reset;
            @(posedge clk); #1;
            if (s_rst) begin
                bus_reqack = 1'b0; bus_respcyc = 1'b0; busy = 1'b0; wait_cnt = 0; beat = 0;
            end else begin
                if (s_beat_hs) beat++;
                if (s_req_hs) begin
                    busy = 1'b1; beat = 0; addr = s_addr; bus_reqack = 1'b0; wait_cnt = 0;
                end else if (!busy && s_reqcyc && !bus_reqack) begin
                    if (wait_cnt >= ack_delay) bus_reqack = 1'b1;
                    else wait_cnt++;
                end
                if (busy && beat == 8) busy = 1'b0;
                if (busy && !(s_beat_hs && resp_gaps)) begin
                    bus_respcyc = 1'b1;
                    bus_resp = {mem(addr + 64'(8 * beat + 4)), mem(addr + 64'(8 * beat))};
                end else begin
                    bus_respcyc = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        inst_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus_reqcyc) begin
                    checks++;
                    if (exp_req.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: bus_req=%h with no request expected", bus_req);
                    end else if (bus_req !== exp_req[0] || bus_reqtag !== 13'h1100) begin
                        errors++;
                        $display("FAIL req_addr: bus_req=%h tag=%h, expected %h tag 1100",
                                 bus_req, bus_reqtag, exp_req[0]);
                    end
                    if (bus_reqack && exp_req.size() != 0) void'(exp_req.pop_front());
                end
                if (inst_valid && inst_ready) begin
                    checks++;
                    if (exp_inst.size() == 0) begin
                        errors++;
                        $display("FAIL inst_unexpected: pc=%h word=%h", inst_pc, inst_word);
                    end else begin
                        e = exp_inst.pop_front();
                        if (inst_pc !== e.pc || inst_word !== e.word) begin
                            errors++;
                            $display("FAIL inst: pc=%h word=%h, expected pc=%h word=%h",
                                     inst_pc, inst_word, e.pc, e.word);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_insts(input logic [63:0] base, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            inst_t t;
            t.pc   = base + 64'(4 * k);
            t.word = mem(t.pc);
            exp_inst.push_back(t);
        end
    endtask

    task automatic do_reset(input logic [63:0] e);
        @(posedge clk); #1;
        reset = 1'b1; entry = e; redirect_valid = 1'b0; redirect_pc = 64'd0;
        exp_inst.delete(); exp_req.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, bus_respack, inst_valid, halted} !== 4'b0 || bus_req !== 64'd0 ||
            bus_reqtag !== 13'd0 || inst_pc !== 64'd0 || inst_word !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: reqcyc=%b respack=%b valid=%b halted=%b req=%h, expected all 0",
                     bus_reqcyc, bus_respack, inst_valid, halted, bus_req);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_inst.size() != 0 || exp_req.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_inst.size() != 0 || exp_req.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d insts and %0d reqs pending, expected 0",
                     exp_inst.size(), exp_req.size());
        end
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        int beats;

        // Aligned entry, full line then sequential advance.
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_insts(64'h1000, 0, 15);
        exp_req.push_back(64'h1040);
        release_reset();
        wait_drain(200);

        // Mid-line entry skips the leading words.
        do_reset(64'h1008);
        exp_req.push_back(64'h1000);
        push_insts(64'h1000, 2, 15);
        exp_req.push_back(64'h1040);
        release_reset();
        wait_drain(200);

        // Zero word at 0x1014 halts after 0x1010; redirect then leaves HALT.
        zero_en = 1'b1; zero_addr = 64'h1014;
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_insts(64'h1000, 0, 4);
        release_reset();
        wait_drain(200);
        n = 0;
        while (!halted && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL halt_reach: halted=%b, expected 1", halted);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (!halted || inst_valid || bus_reqcyc) begin
            errors++;
            $display("FAIL halt_hold: halted=%b valid=%b reqcyc=%b, expected 1 0 0",
                     halted, inst_valid, bus_reqcyc);
        end
        exp_req.push_back(64'h2000);
        push_insts(64'h2000, 0, 15);
        exp_req.push_back(64'h2040);
        pulse_redirect(64'h2000);
        wait_drain(200);
        zero_en = 1'b0;

        // Redirect after beat 3 of the line.
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        exp_req.push_back(64'h2000);
        push_insts(64'h2000, 1, 15);
        exp_req.push_back(64'h2040);
        release_reset();
        beats = 0; n = 0;
        while (beats < 4 && n < 100) begin
            @(negedge clk);
            if (bus_respcyc && bus_respack) beats++;
            n++;
        end
        checks++;
        if (beats < 4) begin
            errors++;
            $display("FAIL beat_wait: saw %0d beats, expected 4", beats);
        end
        pulse_redirect(64'h2004);
        wait_drain(200);

        // Redirect while the request waits for a delayed ack.
        ack_delay = 5;
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        exp_req.push_back(64'h2000);
        push_insts(64'h2000, 0, 15);
        exp_req.push_back(64'h2040);
        release_reset();
        @(posedge clk);
        pulse_redirect(64'h2000);
        wait_drain(300);
        ack_delay = 0;

        // Decoder back-pressure and gaps between response beats.
        ready_toggle = 1'b1; resp_gaps = 1'b1;
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_insts(64'h1000, 0, 15);
        exp_req.push_back(64'h1040);
        release_reset();
        wait_drain(400);
        ready_toggle = 1'b0; resp_gaps = 1'b0;

        // Reset in the middle of draining a line.
        do_reset(64'h3010);
        exp_req.push_back(64'h3000);
        push_insts(64'h3000, 4, 15);
        release_reset();
        n = 0;
        while (exp_inst.size() > 9 && n < 200) begin @(posedge clk); n++; end
        checks++;
        if (exp_inst.size() > 9) begin
            errors++;
            $display("FAIL mid_drain_wait: %0d insts pending, expected at most 9", exp_inst.size());
        end
        do_reset(64'h1020);
        exp_req.push_back(64'h1000);
        push_insts(64'h1000, 8, 15);
        exp_req.push_back(64'h1040);
        release_reset();
        @(negedge clk);
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin
            errors++;
            $display("FAIL req_after_reset: reqcyc=%b req=%h, expected 1 and 1000", bus_reqcyc, bus_req);
        end
        wait_drain(200);

        do_reset(64'h1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
